demux_1x35b_to_40x35b_table: RTL and testbench
==============================================

// Module: demux_1x35b_to_40x35b_table
// PURPOSE
//  Write-side counterpart of the 40:1 x 35b read mux. Holds a 40-entry x 35-bit
//  table and presents it as one flat 1400-bit bus, entry i at [35*i+34:35*i].
//  Single write port, single invalidate port, and a sequential flush engine
//  that clears one entry per cycle.
// PARAMETERS
//  NUM_ENTRIES  40  number of table entries (fixed; flat bus width = 1400)
//  ENTRY_WIDTH  35  bits per entry
//  INDEX_WIDTH  6   width of wr_index / inv_index
// PORTS
//  clk          in   1     clock, all state changes on rising edge
//  rst          in   1     synchronous reset, active high
//  wr_en        in   1     write request
//  wr_index     in   6     entry to write
//  wr_data      in   35    write data
//  wr_ready     out  1     write accepted when wr_en & wr_ready (= ~busy)
//  wr_err       out  1     1-cycle pulse: accepted write had wr_index >= 40
//  inv_en       in   1     invalidate request (clears valid bit only)
//  inv_index    in   6     entry to invalidate
//  flush_req    in   1     start full-table clear
//  busy         out  1     flush in progress
//  flush_done   out  1     1-cycle pulse when flush completes
//  out_entries  out  1400  flat table contents, feeds the read mux
//  entry_valid  out  40    per-entry valid bits
//  occupancy    out  6     count of set valid bits (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all entries 0, entry_valid 0, busy 0, wr_err 0, flush_done 0,
//    occupancy 0, FSM IDLE, flush pointer 0. Reset mid-flush aborts the flush
//    with no flush_done pulse. wr_ready is combinational ~busy, so it is 1 after reset.
//  - Write: if wr_en & wr_ready & wr_index<40, then entry[wr_index] <= wr_data and
//    valid[wr_index] <= 1. Latency 1: the new data is visible on out_entries
//    in the cycle after acceptance.
//  - wr_index 40..63: table unchanged; wr_err=1 for exactly the following cycle.
//  - Invalidate: if inv_en & ~busy & inv_index<40, then valid[inv_index] <= 0 and
//    the data is retained. Out-of-range inv_index is silently ignored.
//  - Write and invalidate to the same index in one cycle: the write wins
//    (valid=1, new data). Different indices: both take effect.
//  - FSM IDLE: flush_req -> FLUSH, with ptr=0 and busy=1 from the next cycle.
//    A write or invalidate presented in the same cycle as flush_req is still
//    applied, and the flush then clears it.
//  - FSM FLUSH: each cycle, entry[ptr] <= 0, valid[ptr] <= 0, ptr++. On the cycle
//    that clears ptr==39, go to IDLE: busy=0 and flush_done=1 in the next cycle.
//    busy is high for exactly 40 cycles.
//  - In FLUSH: wr_en is not accepted (no wr_err is raised); inv_en and
//    flush_req are ignored.
//  - Outputs are registered, except wr_ready.
// CONFIGURATION
//  TABLE_OCCUPANCY_EN defined:
//  - occupancy is a registered count of valid bits, updated on the same edge
//    as entry_valid.
//  - +1 on a write to an invalid entry; -1 on an invalidate of a valid entry.
//  - No change for a write to a valid entry, or for a same-index
//    write+invalidate on a valid entry.
//  - Decremented per cleared valid entry during flush; 0 after flush_done.
//  TABLE_OCCUPANCY_EN not defined: occupancy tied to 6'd0 and no counter logic.
// TESTING
//  1 rst for 2 cycles -> out_entries==0, entry_valid==0, busy=0, wr_ready=1.
//  2 write idx 5, data 35'h1_2345_6789 -> next cycle out_entries[209:175]==
//    35'h1_2345_6789, entry_valid[5]=1; all other bits unchanged.
//  3 write idx 45 -> table unchanged, wr_err=1 for 1 cycle, then 0.
//  4 write idx 39, then flush_req -> busy=1 for 40 cycles; a write during flush
//    sees wr_ready=0 and is dropped; flush_done pulses once; table all 0.
//  5 write idx 7 and inv_en idx 7 in the same cycle -> valid[7]=1, new data
//    stored; next cycle inv idx 7 alone -> valid[7]=0, data retained.
//  6 TABLE_OCCUPANCY_EN: write idx 1,2,3, rewrite idx 2, invalidate idx 1 ->
//    occupancy 1,2,3,3,2; after flush -> 0. Without macro: occupancy stays 0.

Source files
------------

// File: rtl/demux_1x35b_to_40x35b_table.sv
// 40-entry x 35-bit write-side table with write, invalidate and a sequential flush engine.
// Optional registered occupancy counter enabled by defining TABLE_OCCUPANCY_EN.
module demux_1x35b_to_40x35b_table (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [5:0]    wr_index,
    input  logic [34:0]   wr_data,
    output logic          wr_ready,
    output logic          wr_err,
    input  logic          inv_en,
    input  logic [5:0]    inv_index,
    input  logic          flush_req,
    output logic          busy,
    output logic          flush_done,
    output logic [1399:0] out_entries,
    output logic [39:0]   entry_valid,
    output logic [5:0]    occupancy
);

    localparam int NUM_ENTRIES = 40;
    localparam int ENTRY_WIDTH = 35;
    localparam int INDEX_WIDTH = 6;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = 6'd39;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]             state;
    logic [INDEX_WIDTH-1:0] ptr;
    logic                   wr_hit;
    logic                   inv_hit;
    logic                   wr_oob;

    assign busy     = (state == ST_FLUSH);
    assign wr_ready = ~busy;
    assign wr_hit   = wr_en & ~busy & (wr_index < 6'd40);
    assign wr_oob   = wr_en & ~busy & (wr_index >= 6'd40);
    assign inv_hit  = inv_en & ~busy & (inv_index < 6'd40);

    // Table storage lives directly in the flat bus; write is applied after
    // invalidate so a same-index collision leaves the entry valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_entries <= '0;
            entry_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (busy) begin
                    if (ptr == 6'(i)) begin
                        out_entries[i*ENTRY_WIDTH +: ENTRY_WIDTH] <= '0;
                        entry_valid[i]                            <= 1'b0;
                    end
                end else begin
                    if (inv_hit && (inv_index == 6'(i))) begin
                        entry_valid[i] <= 1'b0;
                    end
                    if (wr_hit && (wr_index == 6'(i))) begin
                        out_entries[i*ENTRY_WIDTH +: ENTRY_WIDTH] <= wr_data;
                        entry_valid[i]                            <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            flush_done <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            wr_err     <= wr_oob;
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state <= ST_FLUSH;
                        ptr   <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (ptr == LAST_INDEX) begin
                        state      <= ST_IDLE;
                        ptr        <= '0;
                        flush_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 6'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

`ifdef TABLE_OCCUPANCY_EN
    logic [5:0] occ;
    logic       occ_inc;
    logic       occ_dec;

    // Net change tracks transitions of the valid bits on the same edge.
    always_comb begin
        occ_inc = 1'b0;
        occ_dec = 1'b0;
        if (busy) begin
            occ_dec = entry_valid[ptr];
        end else begin
            occ_inc = wr_hit & ~entry_valid[wr_index];
            occ_dec = inv_hit & entry_valid[inv_index] &
                      ~(wr_hit & (wr_index == inv_index));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= occ + {5'd0, occ_inc} - {5'd0, occ_dec};
        end
    end

    assign occupancy = occ;
`else
    assign occupancy = 6'd0;
`endif

endmodule

// File: tb/tb_demux_1x35b_to_40x35b_table.sv
// Self-checking bench: directed steps plus random traffic against an array-based table model.
// Occupancy expectations follow TABLE_OCCUPANCY_EN the same way as the design.
module tb_demux_1x35b_to_40x35b_table;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [5:0]    wr_index;
    logic [34:0]   wr_data;
    logic          wr_ready;
    logic          wr_err;
    logic          inv_en;
    logic [5:0]    inv_index;
    logic          flush_req;
    logic          busy;
    logic          flush_done;
    logic [1399:0] out_entries;
    logic [39:0]   entry_valid;
    logic [5:0]    occupancy;

    demux_1x35b_to_40x35b_table dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_err      (wr_err),
        .inv_en      (inv_en),
        .inv_index   (inv_index),
        .flush_req   (flush_req),
        .busy        (busy),
        .flush_done  (flush_done),
        .out_entries (out_entries),
        .entry_valid (entry_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays of entries/valid flags and a flush countdown.
    logic [34:0] m_data  [40];
    bit          m_valid [40];
    bit          m_flushing;
    int          m_ptr;
    bit          m_err;
    bit          m_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_table(input string tag);
        logic [1399:0] exp_flat;
        int            bad;
        for (int i = 0; i < 40; i++) exp_flat[i*35 +: 35] = m_data[i];
        checks++;
        assert (out_entries === exp_flat) else begin
            errors++;
            bad = 0;
            for (int i = 39; i >= 0; i--)
                if (out_entries[i*35 +: 35] !== exp_flat[i*35 +: 35]) bad = i;
            $error("[TB] FAIL %s entry %0d observed=%0h expected=%0h", tag, bad,
                   out_entries[bad*35 +: 35], exp_flat[bad*35 +: 35]);
        end
    endtask

    function automatic logic [39:0] model_valid_vec();
        logic [39:0] v;
        for (int i = 0; i < 40; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic int model_occupancy();
        int n = 0;
`ifdef TABLE_OCCUPANCY_EN
        for (int i = 0; i < 40; i++) n += int'(m_valid[i]);
`endif
        return n;
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 40; i++) begin
                m_data[i]  = '0;
                m_valid[i] = 1'b0;
            end
            m_flushing = 1'b0;
            m_ptr      = 0;
            m_err      = 1'b0;
            m_done     = 1'b0;
        end else if (m_flushing) begin
            m_err            = 1'b0;
            m_data[m_ptr]    = '0;
            m_valid[m_ptr]   = 1'b0;
            m_done           = (m_ptr == 39);
            m_flushing       = (m_ptr != 39);
            m_ptr            = m_ptr + 1;
        end else begin
            m_done = 1'b0;
            m_err  = wr_en && (int'(wr_index) >= 40);
            if (inv_en && int'(inv_index) < 40) m_valid[inv_index] = 1'b0;
            if (wr_en && int'(wr_index) < 40) begin
                m_data[wr_index]  = wr_data;
                m_valid[wr_index] = 1'b1;
            end
            if (flush_req) begin
                m_flushing = 1'b1;
                m_ptr      = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_table({tag, ".table"});
        check({tag, ".valid"}, 64'(entry_valid), 64'(model_valid_vec()));
        check({tag, ".busy"}, 64'(busy), 64'(m_flushing));
        check({tag, ".wr_ready"}, 64'(wr_ready), 64'(!m_flushing));
        check({tag, ".wr_err"}, 64'(wr_err), 64'(m_err));
        check({tag, ".flush_done"}, 64'(flush_done), 64'(m_done));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(model_occupancy()));
    endtask

    task automatic idle_inputs();
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_index  = '0;
        wr_data   = '0;
        inv_en    = 1'b0;
        inv_index = '0;
        flush_req = 1'b0;
    endtask

    // One clock: inputs already driven, model advances on the edge, outputs sampled 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_update();
        #1;
        compare_all(tag);
    endtask

    task automatic do_write(input logic [5:0] idx, input logic [34:0] data, input string tag);
        idle_inputs();
        wr_en    = 1'b1;
        wr_index = idx;
        wr_data  = data;
        cycle(tag);
        idle_inputs();
    endtask

    task automatic do_inv(input logic [5:0] idx, input string tag);
        idle_inputs();
        inv_en    = 1'b1;
        inv_index = idx;
        cycle(tag);
        idle_inputs();
    endtask

    int busy_cycles;
    int done_pulses;

    initial begin
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_data[i]  = 'x;
            m_valid[i] = 1'b0;
        end
        m_flushing = 1'b0;

        // Reset
        cycle("reset1");
        cycle("reset2");
        check("reset.out_entries_zero", 64'(out_entries == '0), 64'd1);
        check("reset.wr_ready", 64'(wr_ready), 64'd1);
        idle_inputs();

        // Single write appears one cycle later in the right slice
        do_write(6'd5, 35'h1_2345_6789, "write5");
        check("write5.slice", 64'(out_entries[209:175]), 64'h1_2345_6789);
        check("write5.valid_bit", 64'(entry_valid), 64'h20);

        // Out-of-range write
        do_write(6'd45, 35'h7_FFFF_FFFF, "write45");
        check("write45.err_pulse", 64'(wr_err), 64'd1);
        cycle("write45.after");
        check("write45.err_clear", 64'(wr_err), 64'd0);

        // Flush with a dropped write in the middle
        do_write(6'd39, 35'h5_5555_AAAA, "write39");
        flush_req = 1'b1;
        cycle("flush.start");
        idle_inputs();
        busy_cycles = 0;
        done_pulses = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 10) begin
                wr_en    = 1'b1;
                wr_index = 6'd12;
                wr_data  = 35'h0_0000_BEEF;
                inv_en    = 1'b1;
                inv_index = 6'd5;
                flush_req = 1'b1;
            end else begin
                idle_inputs();
            end
            if (busy === 1'b1) busy_cycles++;
            cycle("flush.run");
            if (c == 10) check("flush.dropped_no_err", 64'(wr_err), 64'd0);
            if (flush_done === 1'b1) done_pulses++;
        end
        idle_inputs();
        check("flush.busy_cycles", 64'(busy_cycles), 64'd40);
        check("flush.done_pulses", 64'(done_pulses), 64'd1);
        check("flush.table_zero", 64'(out_entries == '0), 64'd1);
        check("flush.valid_zero", 64'(entry_valid), 64'd0);

        // Same-index write and invalidate: write wins; then invalidate keeps data
        wr_en     = 1'b1;
        wr_index  = 6'd7;
        wr_data   = 35'h2_CAFE_F00D;
        inv_en    = 1'b1;
        inv_index = 6'd7;
        cycle("wrinv7");
        idle_inputs();
        check("wrinv7.valid", 64'(entry_valid[7]), 64'd1);
        do_inv(6'd7, "inv7");
        check("inv7.valid", 64'(entry_valid[7]), 64'd0);
        check("inv7.data_kept", 64'(out_entries[7*35 +: 35]), 64'h2_CAFE_F00D);

        // Occupancy sequence on a freshly reset table
        rst = 1'b1;
        cycle("occ.reset");
        idle_inputs();
        do_write(6'd1, 35'h11, "occ.w1");
        check("occ.after_w1", 64'(occupancy), 64'(`ifdef TABLE_OCCUPANCY_EN 1 `else 0 `endif));
        do_write(6'd2, 35'h22, "occ.w2");
        check("occ.after_w2", 64'(occupancy), 64'(`ifdef TABLE_OCCUPANCY_EN 2 `else 0 `endif));
        do_write(6'd3, 35'h33, "occ.w3");
        check("occ.after_w3", 64'(occupancy), 64'(`ifdef TABLE_OCCUPANCY_EN 3 `else 0 `endif));
        do_write(6'd2, 35'h44, "occ.rw2");
        check("occ.after_rw2", 64'(occupancy), 64'(`ifdef TABLE_OCCUPANCY_EN 3 `else 0 `endif));
        do_inv(6'd1, "occ.i1");
        check("occ.after_i1", 64'(occupancy), 64'(`ifdef TABLE_OCCUPANCY_EN 2 `else 0 `endif));
        flush_req = 1'b1;
        cycle("occ.flush");
        idle_inputs();
        for (int c = 0; c < 41; c++) cycle("occ.flushrun");
        check("occ.after_flush", 64'(occupancy), 64'd0);

        // Randomized traffic, including occasional flush and reset mid-flush
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            wr_en     = ($urandom_range(0, 99) < 60);
            wr_index  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63))
                                                    : 6'($urandom_range(0, 39));
            wr_data   = 35'({$urandom(), $urandom()});
            inv_en    = ($urandom_range(0, 99) < 30);
            inv_index = ($urandom_range(0, 3) == 0) ? wr_index : 6'($urandom_range(0, 63));
            flush_req = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 299) == 0);
            cycle("rand");
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
